// File: rtl/spi_slave_mclk_if.sv
// SPI pins plus the SoC-side TX/RX handshake of the mclk-domain SPI responder.
// The slave modport is the responder side; the master modport drives both the SPI pins and the SoC strobes.
interface spi_slave_mclk_if #(
  parameter int unsigned WIDTH = 8
);
  logic             sclk;
  logic             cs;
  logic             mosi;
  logic             miso;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             read;
  logic [WIDTH-1:0] data_out;
  logic             rx_valid;
  logic             tx_full;
  logic             busy;
  logic             overrun;

  modport slave (
    input  sclk, cs, mosi, load, data_in, read,
    output miso, data_out, rx_valid, tx_full, busy, overrun
  );

  modport master (
    output sclk, cs, mosi, load, data_in, read,
    input  miso, data_out, rx_valid, tx_full, busy, overrun
  );
endinterface

// File: rtl/spi_slave_mclk.sv
// Mode-0, MSB-first SPI responder clocked only by mclk; sclk/cs/mosi are oversampled.
// Provides a 1-deep TX buffer and a 1-deep RX holding register with sticky overrun.
module spi_slave_mclk #(
  parameter int unsigned     WIDTH       = 8,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] DEFAULT_TX = WIDTH'(8'hFF)
) (
  input logic              mclk,
  input logic              reset,
  spi_slave_mclk_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Input synchronizers; cs resets to its inactive (high) level
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [WIDTH-1:0]   tx_buf_q,   tx_buf_d;
  logic [WIDTH-1:0]   tx_sr_q,    tx_sr_d;
  logic [WIDTH-1:0]   rx_sr_q,    rx_sr_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               miso_q,     miso_d;
  logic               rx_valid_q, rx_valid_d;
  logic               tx_full_q,  tx_full_d;
  logic               busy_q,     busy_d;
  logic               overrun_q,  overrun_d;
  logic [WIDTH-1:0]   tx_next_c;
  logic [WIDTH-1:0]   rx_byte_c;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_buf_q   <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      data_out_q <= '0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_full_q  <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_buf_q   <= tx_buf_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      data_out_q <= data_out_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      tx_full_q  <= tx_full_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state and next-output logic; read is applied first so a same-cycle
  // byte completion re-asserts rx_valid, and load is applied last so a
  // same-cycle reload takes the old buffer while tx_full ends up set.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_buf_d   = tx_buf_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    data_out_d = data_out_q;
    miso_d     = miso_q;
    rx_valid_d = rx_valid_q;
    tx_full_d  = tx_full_q;
    overrun_d  = overrun_q;
    busy_d     = ~cs_s;
    tx_next_c  = tx_full_q ? tx_buf_q : DEFAULT_TX;
    rx_byte_c  = {rx_sr_q[WIDTH-2:0], mosi_s};

    if (bus.read) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (!cs_s) begin
          state_d   = ACTIVE;
          tx_sr_d   = tx_next_c;
          tx_full_d = 1'b0;
          bit_cnt_d = '0;
          rx_sr_d   = '0;
          miso_d    = tx_next_c[WIDTH-1];
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          tx_sr_d   = '0;
          rx_sr_d   = '0;
          miso_d    = 1'b0;
        end else if (sclk_rise) begin
          rx_sr_d   = rx_byte_c;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            bit_cnt_d  = '0;
            data_out_d = rx_byte_c;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !bus.read) begin
              overrun_d = 1'b1;
            end
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != '0) begin
            tx_sr_d = tx_sr_q << 1;
            miso_d  = tx_sr_q[WIDTH-2];
          end else begin
            // Byte boundary with cs still low: start the next byte
            tx_sr_d   = tx_next_c;
            tx_full_d = 1'b0;
            miso_d    = tx_next_c[WIDTH-1];
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.load) begin
      tx_buf_d  = bus.data_in;
      tx_full_d = 1'b1;
    end
  end

  assign bus.miso     = miso_q;
  assign bus.data_out = data_out_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_full  = tx_full_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_mclk.sv
// Bench for spi_slave_mclk: bit-banged SPI master, TX-buffer reference model,
// and an RX scoreboard drained by an independent monitor.
module tb_spi_slave_mclk;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned HALF   = 4;
  localparam logic [7:0]  DEF_TX = 8'hFF;

  logic mclk  = 1'b0;
  logic reset = 1'b1;

  spi_slave_mclk_if #(.WIDTH(WIDTH)) bus ();

  spi_slave_mclk #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(2),
    .DEFAULT_TX (DEF_TX)
  ) dut (
    .mclk (mclk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 mclk = ~mclk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_buf  = 8'h00;
  bit         m_full = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a new received byte shows as rx_valid rising or data_out changing while valid
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge mclk) begin
    if (!reset && bus.rx_valid && (!prev_valid || bus.data_out !== prev_data)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rx_unexpected: got %0h expected none", bus.data_out);
      end else begin
        check("rx_byte", 32'(bus.data_out), 32'(exp_q.pop_front()));
      end
    end
    prev_valid = bus.rx_valid;
    prev_data  = bus.data_out;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic do_load(input logic [7:0] d);
    bus.data_in = d;
    bus.load    = 1'b1;
    wait_cyc(1);
    bus.load    = 1'b0;
    m_buf       = d;
    m_full      = 1'b1;
  endtask

  task automatic do_read();
    bus.read = 1'b1;
    wait_cyc(1);
    bus.read = 1'b0;
  endtask

  // Shift nbits of mo (MSB first) while collecting miso on each rising sclk
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[7-i];
      wait_cyc(HALF);
      mi = {mi[6:0], bus.miso};
      bus.sclk = 1'b1;
      wait_cyc(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.cs = 1'b0;
    wait_cyc(2 * HALF);
    check("busy_in_frame", 32'(bus.busy), 32'd1);
  endtask

  task automatic cs_high();
    wait_cyc(HALF);
    bus.cs = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  // Full frame of n (1 or 2) back-to-back bytes; each byte slot consumes the TX buffer
  task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input int n);
    logic [7:0] mi;
    logic [7:0] exp_tx;
    logic [7:0] mo;
    cs_low();
    for (int k = 0; k < n; k++) begin
      mo     = (k == 0) ? b0 : b1;
      exp_tx = m_full ? m_buf : DEF_TX;
      m_full = 1'b0;
      exp_q.push_back(mo);
      spi_bits(mo, 8, mi);
      check("miso_byte", 32'(mi), 32'(exp_tx));
    end
    cs_high();
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] b0, b1;
    int         nb;

    bus.sclk    = 1'b0;
    bus.cs      = 1'b1;
    bus.mosi    = 1'b0;
    bus.load    = 1'b0;
    bus.read    = 1'b0;
    bus.data_in = 8'h00;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(6);

    check("rst_miso",     32'(bus.miso),     32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_tx_full",  32'(bus.tx_full),  32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_overrun",  32'(bus.overrun),  32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);

    do_load(8'hA5);
    check("tx_full_after_load", 32'(bus.tx_full), 32'd1);
    spi_frame(8'h3C, 8'h00, 1);
    check("t2_data_out", 32'(bus.data_out), 32'h3C);
    check("t2_rx_valid", 32'(bus.rx_valid), 32'd1);
    check("t2_tx_full",  32'(bus.tx_full),  32'd0);
    check("idle_busy",   32'(bus.busy),     32'd0);
    do_read();
    check("t2_read_clr", 32'(bus.rx_valid), 32'd0);
    check("t2_read_hold", 32'(bus.data_out), 32'h3C);

    spi_frame(8'h81, 8'h00, 1);
    check("t3_data_out", 32'(bus.data_out), 32'h81);
    do_read();

    spi_frame(8'h12, 8'h34, 2);
    check("t4_data_out", 32'(bus.data_out), 32'h34);
    check("t4_overrun",  32'(bus.overrun),  32'd1);
    do_read();
    check("t4_rx_valid_clr", 32'(bus.rx_valid), 32'd0);
    check("t4_overrun_clr",  32'(bus.overrun),  32'd0);

    // Partial frame: 5 bits then cs high; nothing is received
    cs_low();
    m_full = 1'b0;
    spi_bits(8'hF0, 5, mi);
    cs_high();
    check("t5_no_rx",   32'(bus.rx_valid), 32'd0);
    check("t5_miso_lo", 32'(bus.miso),     32'd0);
    spi_frame(8'h0F, 8'h00, 1);
    check("t5_data_out", 32'(bus.data_out), 32'h0F);

    // Reset mid-frame at bit 3 with rx_valid, tx_full and busy all set
    cs_low();
    m_full = 1'b0;
    spi_bits(8'hAA, 2, mi);
    do_load(8'hC3);
    spi_bits(8'hAA, 1, mi);
    reset = 1'b1;
    #1;
    check("t6_miso",     32'(bus.miso),     32'd0);
    check("t6_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("t6_tx_full",  32'(bus.tx_full),  32'd0);
    check("t6_busy",     32'(bus.busy),     32'd0);
    check("t6_overrun",  32'(bus.overrun),  32'd0);
    check("t6_data_out", 32'(bus.data_out), 32'd0);
    bus.cs   = 1'b1;
    bus.sclk = 1'b0;
    m_full   = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(6);
    spi_frame(8'h55, 8'h00, 1);
    check("t6_data_out_after", 32'(bus.data_out), 32'h55);
    do_read();

    // Randomized frames: optional load, 1 or 2 bytes per frame
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 1) == 1) do_load(8'($urandom));
      nb = int'($urandom_range(1, 2));
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      if (b1 == b0) b1 = b0 ^ 8'h01;
      spi_frame(b0, b1, nb);
      check("rnd_rx_valid", 32'(bus.rx_valid), 32'd1);
      check("rnd_overrun",  32'(bus.overrun),  (nb == 2) ? 32'd1 : 32'd0);
      check("rnd_tx_full",  32'(bus.tx_full),  32'd0);
      do_read();
    end

    wait_cyc(4);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
